// File: rtl/axis_spi_master_core.sv
// AXI4-Stream to SPI master bridge: each accepted stream word is shifted out MSB-first
// on MOSI while the word clocked in on MISO is returned on the master stream.
module axis_spi_master_core #(
   parameter int SPI_MODE   = 3,
   parameter int DATA_WIDTH = 8,
   parameter int MAIN_CLK   = 27_000_000,
   parameter int SPI_CLK    = 6_750_000,
   parameter int SLAVE_NUM  = 1,
   parameter int WAIT_TIME  = 50,
   localparam int ADDR_W    = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [ADDR_W-1:0]     addr_i,
   output logic                  spi_clk_o,
   output logic [SLAVE_NUM-1:0]  spi_cs_o,
   output logic                  spi_mosi_o,
   input  logic                  spi_miso_i,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready
);

   localparam int HALF_RAW       = MAIN_CLK / (2 * SPI_CLK);
   localparam int HALF           = (HALF_RAW < 1) ? 1 : HALF_RAW;
   localparam logic [1:0] MODE   = 2'(SPI_MODE);
   localparam logic CPOL         = MODE[1];
   localparam logic CPHA         = MODE[0];
   localparam int DIV_W          = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int EDGES          = 2 * DATA_WIDTH;
   localparam int EDGE_W         = $clog2(EDGES + 1);
   localparam int WAIT_W         = (WAIT_TIME > 1) ? $clog2(WAIT_TIME) : 1;
   localparam int WAIT_LAST      = (WAIT_TIME > 0) ? WAIT_TIME - 1 : 0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_XFER,
      ST_HOLD,
      ST_WAIT
   } state_t;

   state_t                state, state_nxt;
   logic [DIV_W-1:0]      div_cnt;
   logic [EDGE_W-1:0]     edge_cnt;
   logic [WAIT_W-1:0]     wait_cnt;
   logic [DATA_WIDTH-1:0] tx_sr;
   logic [DATA_WIDTH-1:0] tx_next;
   logic [DATA_WIDTH-1:0] rx_sr;
   logic [ADDR_W-1:0]     addr_q;

   logic s_hs;
   logic m_hs;
   logic half_tick;
   logic edge_tick;
   logic last_edge;
   logic leading;
   logic shift_ev;
   logic sample_ev;
   logic hold_done;
   logic wait_done;

   // Holding off new words while a result is pending is what prevents receive overflow.
   assign s_axis_tready = (state == ST_IDLE) && !m_axis_tvalid && !rst_i;
   assign s_hs          = s_axis_tvalid && s_axis_tready;
   assign m_hs          = m_axis_tvalid && m_axis_tready;
   assign half_tick     = (div_cnt == DIV_W'(HALF - 1));
   assign edge_tick     = (state == ST_XFER) && half_tick;
   assign last_edge     = edge_tick && (edge_cnt == EDGE_W'(EDGES - 1));
   assign leading       = !edge_cnt[0];
   assign hold_done     = (state == ST_HOLD) && half_tick;
   assign wait_done     = (state == ST_WAIT) && (wait_cnt == WAIT_W'(WAIT_LAST));
   assign tx_next       = tx_sr << 1;

   // CPHA=0 shifts on trailing edges (never after the final edge); CPHA=1 on leading edges.
   assign shift_ev  = edge_tick && (CPHA ? leading : (!leading && !last_edge));
   assign sample_ev = edge_tick && (CPHA ? !leading : leading);

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (s_hs)      state_nxt = ST_XFER;
         ST_XFER: if (last_edge) state_nxt = ST_HOLD;
         ST_HOLD: if (hold_done) state_nxt = ST_WAIT;
         ST_WAIT: if (wait_done) state_nxt = ST_IDLE;
         default:                state_nxt = ST_IDLE;
      endcase
   end

   // An out-of-range address leaves every select high while the word still runs.
   always_comb begin
      spi_cs_o = '1;
      if ((state == ST_XFER) || (state == ST_HOLD)) begin
         for (int i = 0; i < SLAVE_NUM; i++) begin
            if (addr_q == ADDR_W'(i)) spi_cs_o[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         div_cnt  <= '0;
         edge_cnt <= '0;
         wait_cnt <= '0;
      end else begin
         div_cnt <= ((state == ST_IDLE) || half_tick) ? '0 : div_cnt + 1'b1;
         if (state == ST_IDLE)  edge_cnt <= '0;
         else if (edge_tick)    edge_cnt <= edge_cnt + 1'b1;
         if (state != ST_WAIT)  wait_cnt <= '0;
         else                   wait_cnt <= wait_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (s_hs) begin
         tx_sr  <= s_axis_tdata;
         addr_q <= addr_i;
      end else if (shift_ev) begin
         tx_sr  <= tx_next;
      end
      if (sample_ev) rx_sr <= (rx_sr << 1) | DATA_WIDTH'(spi_miso_i);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         spi_clk_o     <= CPOL;
         spi_mosi_o    <= 1'b0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
      end else begin
         if (edge_tick) spi_clk_o <= ~spi_clk_o;
         if (s_hs && !CPHA)  spi_mosi_o <= s_axis_tdata[DATA_WIDTH-1];
         else if (shift_ev)  spi_mosi_o <= CPHA ? tx_sr[DATA_WIDTH-1] : tx_next[DATA_WIDTH-1];
         if (hold_done) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= rx_sr;
         end else if (m_hs) begin
            m_axis_tvalid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_axis_spi_master_core.sv
// Bench for axis_spi_master_core: four loopback instances (SPI modes 0..3) run in lockstep
// from shared stream inputs; a reference slave and a scoreboard check every returned word.
module tb_axis_spi_master_core;

   localparam int HALF   = 2;
   localparam int WAIT_T = 50;

   logic       clk = 1'b0;
   logic       rst;
   logic [0:0] addr;
   logic [7:0] s_tdata;
   logic       s_tvalid;
   logic       m_tready;
   logic [3:0] sclk, mosi, cs, s_tready, m_tvalid;
   logic [7:0] m_tdata [4];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      axis_spi_master_core #(
         .SPI_MODE(g), .DATA_WIDTH(8), .MAIN_CLK(27_000_000), .SPI_CLK(6_750_000),
         .SLAVE_NUM(1), .WAIT_TIME(WAIT_T)
      ) dut (
         .clk_i(clk), .rst_i(rst), .addr_i(addr),
         .spi_clk_o(sclk[g]), .spi_cs_o(cs[g:g]), .spi_mosi_o(mosi[g]), .spi_miso_i(mosi[g]),
         .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready[g]),
         .m_axis_tdata(m_tdata[g]), .m_axis_tvalid(m_tvalid[g]), .m_axis_tready(m_tready)
      );
   end

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   logic [7:0] exp_q [$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Monitor state for instance 3 timing plus a reference SPI slave per instance.
   logic       prev_cs = 1'b1, prev_rdy = 1'b0, cs_seen_low = 1'b0;
   logic [3:0] prev_sclk = 4'b0;
   int low_len = 0, last_low_len = 0, tog_cnt = 0, last_tog_cnt = 0;
   int first_tog = -1, last_tog_cyc = 0, gap_bad = 0, cs_fall_cyc = 0, cs_rise_cyc = 0;
   int hs_cyc = 0, m_hs_cyc = 0, rdy_gap = 0, word_time = 0;
   int edge_n [4];
   logic [7:0] mon_sr [4];

   always @(negedge clk) begin
      if (rst) begin
         prev_cs   = cs[3];
         prev_sclk = sclk;
         prev_rdy  = s_tready[3];
      end else begin
         if (!prev_rdy && s_tready[3]) begin
            rdy_gap   = cyc - cs_rise_cyc;
            word_time = cyc - hs_cyc;
         end
         if (s_tvalid && s_tready[3]) begin
            hs_cyc      = cyc;
            cs_seen_low = 1'b0;
            for (int i = 0; i < 4; i++) begin
               edge_n[i] = 0;
               mon_sr[i] = 8'h00;
            end
         end
         if (!cs[3]) begin
            cs_seen_low = 1'b1;
            if (prev_cs) begin
               cs_fall_cyc = cyc;
               low_len     = 0;
               tog_cnt     = 0;
               gap_bad     = 0;
               first_tog   = -1;
            end
            low_len++;
            if (sclk[3] != prev_sclk[3]) begin
               if (tog_cnt == 0) first_tog = cyc - cs_fall_cyc;
               else if (cyc - last_tog_cyc != HALF) gap_bad++;
               tog_cnt++;
               last_tog_cyc = cyc;
            end
         end else if (!prev_cs) begin
            last_low_len = low_len;
            last_tog_cnt = tog_cnt;
            cs_rise_cyc  = cyc;
         end
         for (int i = 0; i < 4; i++) begin
            if (sclk[i] != prev_sclk[i]) begin
               edge_n[i]++;
               if ((edge_n[i] % 2 == 1) == (i % 2 == 0)) mon_sr[i] = {mon_sr[i][6:0], mosi[i]};
            end
         end
         if (m_tvalid[3] && m_tready) begin
            logic [7:0] e;
            m_hs_cyc = cyc;
            chk("sb_nonempty", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               for (int i = 0; i < 4; i++) begin
                  chk($sformatf("rx_m%0d", i), m_tdata[i], e);
                  chk($sformatf("mosi_m%0d", i), mon_sr[i], e);
                  chk($sformatf("tvalid_m%0d", i), m_tvalid[i], 1);
                  chk($sformatf("sclk_idle_m%0d", i), sclk[i], i / 2);
               end
            end
         end
         prev_cs   = cs[3];
         prev_sclk = sclk;
         prev_rdy  = s_tready[3];
      end
   end

   task automatic send(input logic [7:0] d, input bit push);
      int n = 0;
      @(posedge clk); #1;
      s_tdata  = d;
      s_tvalid = 1'b1;
      @(negedge clk);
      while (!s_tready[3] && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("s_ready_wait", s_tready[3], 1);
      if (push) exp_q.push_back(d);
      @(posedge clk); #1;
      s_tvalid = 1'b0;
   endtask

   task automatic wait_mvalid();
      int n = 0;
      while (!m_tvalid[3] && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("m_valid_wait", m_tvalid[3], 1);
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (!(s_tready[3] && !m_tvalid[3]) && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("idle_wait", s_tready[3], 1);
   endtask

   task automatic pulse_ready();
      @(posedge clk); #1;
      m_tready = 1'b1;
      @(posedge clk); #1;
      m_tready = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int bad;
      rst = 1'b1; addr = 1'b0; s_tdata = 8'h00; s_tvalid = 1'b0; m_tready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("rst_cs_m%0d", i), cs[i], 1);
         chk($sformatf("rst_sclk_m%0d", i), sclk[i], i / 2);
         chk($sformatf("rst_mosi_m%0d", i), mosi[i], 0);
         chk($sformatf("rst_sready_m%0d", i), s_tready[i], 0);
         chk($sformatf("rst_mvalid_m%0d", i), m_tvalid[i], 0);
         chk($sformatf("rst_mdata_m%0d", i), m_tdata[i], 0);
      end
      @(posedge clk); #1;
      rst = 1'b0;

      // Single word 0xA5: CS window and SCLK shape on the mode-3 instance.
      send(8'hA5, 1'b1);
      wait_mvalid();
      @(negedge clk);
      chk("cs_low_len", last_low_len, 2 * 8 * HALF + HALF);
      chk("sclk_toggles", last_tog_cnt, 16);
      chk("first_edge_delay", first_tog, HALF);
      chk("sclk_gap_errors", gap_bad, 0);
      chk("a5_data_held", m_tdata[3], 8'hA5);
      pulse_ready();

      // 0x81 across all four modes.
      send(8'h81, 1'b1);
      wait_mvalid();
      pulse_ready();

      // Back-pressure: result 0x3C held, next word blocked until release.
      send(8'h3C, 1'b1);
      wait_mvalid();
      @(posedge clk); #1;
      s_tdata  = 8'h77;
      s_tvalid = 1'b1;
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (!m_tvalid[3] || m_tdata[3] !== 8'h3C || s_tready[3]) bad++;
      end
      chk("hold_stable", bad, 0);
      @(posedge clk); #1;
      m_tready = 1'b1;
      send(8'h77, 1'b1);
      chk("accept_after_release", hs_cyc - m_hs_cyc, 1);

      // Back-to-back words with the sink always ready.
      wait_idle();
      send(8'h11, 1'b1);
      send(8'h22, 1'b1);
      chk("cs_high_to_ready", rdy_gap, WAIT_T);
      chk("word_time", word_time, 1 + 2 * 8 * HALF + HALF + WAIT_T);
      wait_idle();
      m_tready = 1'b0;

      // Address beyond SLAVE_NUM: no select drops, word still loops back.
      addr = 1'b1;
      send(8'h6B, 1'b1);
      addr = 1'b0;
      wait_mvalid();
      @(negedge clk);
      chk("oor_cs_never_low", cs_seen_low, 0);
      pulse_ready();

      // Random bytes with random source/sink delays.
      for (int k = 0; k < 10; k++) begin
         logic [7:0] d;
         d = 8'($urandom_range(0, 255));
         repeat ($urandom_range(0, 10)) @(posedge clk);
         send(d, 1'b1);
         wait_mvalid();
         repeat ($urandom_range(0, 10)) @(posedge clk);
         pulse_ready();
      end

      // Reset during bit 4 aborts the word; the next word runs normally.
      send(8'h96, 1'b0);
      repeat (17) @(posedge clk);
      #1;
      chk("pre_abort_cs_low", cs[3], 0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("abort_cs_m%0d", i), cs[i], 1);
         chk($sformatf("abort_sclk_m%0d", i), sclk[i], i / 2);
         chk($sformatf("abort_mvalid_m%0d", i), m_tvalid[i], 0);
      end
      send(8'h5A, 1'b1);
      wait_mvalid();
      pulse_ready();

      repeat (5) @(negedge clk);
      chk("sb_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
